// File: rtl/pipe_hazard_intr_ctrl_if.sv
// pipe_hazard_intr_ctrl_if: datapath-facing signal bundle for the pipeline controller
interface pipe_hazard_intr_ctrl_if;
   logic [31:0] IFID_IR;
   logic [4:0]  IDEX_TA;
   logic        IDEX_MemRd;
   logic        Branch_s;
   logic        irq;
   logic        ie_set;
   logic        ie_clr;
   logic        Flush;
   logic        Stall;
   logic        IE;
   logic        ISR;
   logic [2:0]  LISR;
   logic        in_isr;
   modport master (
      output IFID_IR, IDEX_TA, IDEX_MemRd, Branch_s, irq, ie_set, ie_clr,
      input  Flush, Stall, IE, ISR, LISR, in_isr
   );
   modport slave (
      input  IFID_IR, IDEX_TA, IDEX_MemRd, Branch_s, irq, ie_set, ie_clr,
      output Flush, Stall, IE, ISR, LISR, in_isr
   );
endinterface

// File: rtl/pipe_hazard_intr_ctrl.sv
// pipe_hazard_intr_ctrl: load-use stall, branch flush and interrupt entry/exit sequencing
module pipe_hazard_intr_ctrl #(
   parameter int         DRAIN_CYCLES = 3,
   parameter logic [5:0] RET_OPCODE   = 6'b010000
) (
   input logic clk,
   input logic rst,
   pipe_hazard_intr_ctrl_if.slave bus
);
   localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, DRAIN, ENTER, SERVICE, LEAVE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] lisr, lisr_n;
   logic ie, in_isr, load_use, isr, flush, stall, ret_ok, leave_done;
   assign load_use = bus.IDEX_MemRd && bus.IDEX_TA != 5'd0 &&
                     (bus.IDEX_TA == bus.IFID_IR[25:21] || bus.IDEX_TA == bus.IFID_IR[20:16]);
   assign isr = state == ENTER;
   assign flush = bus.Branch_s | isr;
   assign stall = ~flush & (state == DRAIN | load_use);
   assign ret_ok = bus.IFID_IR[31:26] == RET_OPCODE && !stall && !flush;
   assign leave_done = state == LEAVE && lisr[2];
   assign bus.Flush = flush;
   assign bus.Stall = stall;
   assign bus.ISR = isr;
   assign bus.IE = ie;
   assign bus.LISR = lisr;
   assign bus.in_isr = in_isr;
   // state, drain counter and return token registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         lisr <= 3'b000;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         lisr <= lisr_n;
      end
   end
   // next state: branch in MEM defers entry; branch while token is in EX kills the return
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      lisr_n = lisr;
      case (state)
         IDLE:
            if (bus.irq && ie && !bus.Branch_s) begin
               state_n = DRAIN;
               cnt_n = CW'(DRAIN_CYCLES - 1);
            end
         DRAIN:
            if (cnt == '0) state_n = ENTER;
            else cnt_n = cnt - CW'(1);
         ENTER: state_n = SERVICE;
         SERVICE:
            if (ret_ok) begin
               lisr_n = 3'b001;
               state_n = LEAVE;
            end
         LEAVE:
            if (lisr[0] && bus.Branch_s) begin
               lisr_n = 3'b000;
               state_n = SERVICE;
            end else if (lisr[2]) begin
               lisr_n = 3'b000;
               state_n = IDLE;
            end else lisr_n = lisr << 1;
         default: state_n = IDLE;
      endcase
   end
   // interrupt enable and in-service status; sequencer events outrank software pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ie <= 1'b0;
         in_isr <= 1'b0;
      end else if (isr) begin
         ie <= 1'b0;
         in_isr <= 1'b1;
      end else if (leave_done) begin
         ie <= 1'b1;
         in_isr <= 1'b0;
      end else if (bus.ie_clr) ie <= 1'b0;
      else if (bus.ie_set) ie <= 1'b1;
   end
endmodule
